// File: rtl/restoring_divider_if.sv
// Operand/result handshake bundle for restoring_divider: dividend/divisor
// with dov on the request side; quotient/remainder/div_by_zero with done
// and busy on the response side. N must match the divider's N.
interface restoring_divider_if #(
    parameter int unsigned N = 2
);
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           dov;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           div_by_zero;

    modport master (
        output dividend, divisor, dov,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  dividend, divisor, dov,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor
// giving a 2N-bit quotient and N-bit remainder, one quotient bit per clock.
// Handshake: dov accepted while idle, done pulses one cycle with results.
// Optional build macro RESTDIV_DIVZ_FAST_EN: a zero divisor bypasses the
// iteration and completes one cycle after accept.
module restoring_divider #(
    parameter int unsigned N = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    restoring_divider_if.slave     bus
);
    localparam int unsigned CW = (2*N > 1) ? $clog2(2*N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(2*N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DIVZ = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N:0]      rem_q;
    logic [2*N-1:0]  dq_q;
    logic [N-1:0]    dvs_q;

    logic [N:0]      shifted;
    logic [N:0]      trial;
    logic            take;
    logic [N:0]      next_rem;
    logic [2*N-1:0]  next_dq;

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor, keep the difference when it does not go negative.
    // rem_q[N] is the bit shifted out of the N+1-bit window; when set, the
    // true shifted value already exceeds any N-bit divisor, so the trial wins.
    always_comb begin
        shifted  = {rem_q[N-1:0], dq_q[2*N-1]};
        trial    = shifted - {1'b0, dvs_q};
        take     = rem_q[N] | (shifted >= {1'b0, dvs_q});
        next_rem = take ? trial : shifted;
        next_dq  = {dq_q[2*N-2:0], take};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            rem_q           <= '0;
            dq_q            <= '0;
            dvs_q           <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.dov) begin
                        dq_q     <= bus.dividend;
                        dvs_q    <= bus.divisor;
                        rem_q    <= '0;
                        cnt      <= CNT_LAST;
                        bus.busy <= 1'b1;
`ifdef RESTDIV_DIVZ_FAST_EN
                        state    <= (bus.divisor == '0) ? DIVZ : RUN;
`else
                        state    <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem_q <= next_rem;
                    dq_q  <= next_dq;
                    if (cnt == '0) begin
                        bus.quotient    <= next_dq;
                        bus.remainder   <= next_rem[N-1:0];
                        bus.div_by_zero <= (dvs_q == '0);
                        bus.done        <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DIVZ: begin
                    // Same values the full iteration yields for a zero divisor.
                    bus.quotient    <= '1;
                    bus.remainder   <= dq_q[N-1:0];
                    bus.div_by_zero <= 1'b1;
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider with N=2.
// Honours RESTDIV_DIVZ_FAST_EN for the zero-divisor latency.
module tb_restoring_divider;
    localparam int unsigned N = 2;
    localparam int unsigned NORM_LAT = 2*N;
`ifdef RESTDIV_DIVZ_FAST_EN
    localparam int unsigned DIVZ_LAT = 1;
`else
    localparam int unsigned DIVZ_LAT = 2*N;
`endif

    logic clk;
    logic reset;
    int unsigned errors;
    int unsigned checks;

    restoring_divider_if #(.N(N)) bus ();

    restoring_divider #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge: present operands with dov for one edge, return
    // at the negedge right after the accept edge.
    task automatic start(input int unsigned dd, input int unsigned dv);
        bus.dividend = 4'(dd);
        bus.divisor  = 2'(dv);
        bus.dov      = 1'b1;
        @(negedge clk);
        bus.dov      = 1'b0;
    endtask

    // k0 = edges already elapsed since the accept edge.
    task automatic wait_done(input string tag, input int unsigned k0,
                             input int unsigned lat, input int unsigned eq,
                             input int unsigned er, input int unsigned ez);
        int unsigned k;
        bit          seen;
        k    = k0;
        seen = 1'b0;
        while (k <= 30 && !seen) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                check({tag, " busy"}, bus.busy, 1);
                @(negedge clk);
                k = k + 1;
            end
        end
        check({tag, " timeout"}, seen, 1);
        if (seen) begin
            check({tag, " latency"}, k, lat);
            check({tag, " busy@done"}, bus.busy, 0);
            check({tag, " quotient"}, bus.quotient, eq);
            check({tag, " remainder"}, bus.remainder, er);
            check({tag, " div_by_zero"}, bus.div_by_zero, ez);
        end
    endtask

    initial begin
        int unsigned ndone;
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        bus.dov      = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst quotient", bus.quotient, 0);
        check("rst remainder", bus.remainder, 0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst divz", bus.div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        // 9 / 2
        start(9, 2);
        wait_done("9/2", 0, NORM_LAT, 4, 1, 0);
        @(negedge clk);
        check("9/2 done pulse", bus.done, 0);
        check("9/2 held q", bus.quotient, 4);

        // 15 / 3 followed by 6 / 1 accepted in the done cycle
        start(15, 3);
        wait_done("15/3", 0, NORM_LAT, 5, 0, 0);
        start(6, 1);
        check("b2b no done", bus.done, 0);
        wait_done("6/1", 0, NORM_LAT, 6, 0, 0);
        @(negedge clk);

        // 6 / 0
        start(6, 0);
        wait_done("6/0", 0, DIVZ_LAT, 15, 2, 1);
        @(negedge clk);
        check("6/0 held divz", bus.div_by_zero, 1);

        // 13 / 3 with an ignored 8 / 2 while busy
        start(13, 3);
        @(negedge clk);
        bus.dividend = 4'd8;
        bus.divisor  = 2'd2;
        bus.dov      = 1'b1;
        @(negedge clk);
        bus.dov      = 1'b0;
        wait_done("13/3", 2, NORM_LAT, 4, 1, 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) ndone = ndone + 1;
        end
        check("ignored dov extra done", ndone, 0);

        // 12 / 3 aborted by reset during RUN
        start(12, 3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort quotient", bus.quotient, 0);
        check("abort remainder", bus.remainder, 0);
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort divz", bus.div_by_zero, 0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) ndone = ndone + 1;
        end
        check("abort no done", ndone, 0);
        start(10, 3);
        wait_done("10/3", 0, NORM_LAT, 3, 1, 0);
        @(negedge clk);

        // All 16 x 4 operand pairs
        for (int unsigned dd = 0; dd < 16; dd++) begin
            for (int unsigned dv = 0; dv < 4; dv++) begin
                int unsigned eq, er, ez, el;
                if (dv != 0) begin
                    eq = dd / dv;
                    er = dd % dv;
                    ez = 0;
                    el = NORM_LAT;
                end else begin
                    eq = 15;
                    er = dd % 4;
                    ez = 1;
                    el = DIVZ_LAT;
                end
                start(dd, dv);
                wait_done($sformatf("ex %0d/%0d", dd, dv), 0, el, eq, er, ez);
                @(negedge clk);
            end
        end

        // Product of a 2x2 multiply divided back by its factor
        for (int unsigned a = 0; a < 4; a++) begin
            for (int unsigned b = 1; b < 4; b++) begin
                start(a * b, b);
                wait_done($sformatf("mul %0d*%0d/%0d", a, b, b), 0, NORM_LAT, a, 0, 0);
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential radix-2 restoring divider. It is the inverse datapath of the vedic multiplier tree.
- Accepts a 2N-bit dividend (e.g. a product from the multiplier stage) and an N-bit divisor.
- Returns a 2N-bit quotient and an N-bit remainder.
- Uses the same dov (operands valid in) / done (result valid out) handshake as the multiplier blocks, so it can sit directly behind them in the matrix datapath.

Parameters:
N, 2, divisor/remainder width; dividend/quotient width is 2N.

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
dividend  input  2N  numerator, sampled when dov accepted
divisor  input  N  denominator, sampled when dov accepted
dov  input  1  operands valid; accepted only when busy=0
quotient  output  2N  registered quotient, held until next completion
remainder  output  N  registered remainder, held until next completion
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, quotient/remainder valid
div_by_zero  output  1  high with done when the captured divisor was 0; held with results

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, FSM=IDLE, iteration counter=0. Reset has priority over all other inputs.
- Reset mid-operation aborts the operation; no done is produced for it.
- FSM states:
  - IDLE: on a posedge with dov=1, capture dividend into a shift register and divisor into a register. Clear the partial remainder (N+1 bits). Load counter=2N-1. Go to RUN; busy=1 from the next cycle.
  - RUN: each posedge does one step:
    - shift {partial remainder, dividend MSB} left by 1;
    - trial = shifted - {0,divisor};
    - if trial is non-negative, partial = trial and quotient bit = 1;
    - else partial = shifted and quotient bit = 0;
    - quotient bits enter at the LSB of the shift register.
    - On the step with counter=0: load quotient/remainder outputs, set div_by_zero, pulse done, go to IDLE. Otherwise decrement counter.
- Latency:
  - dov sampled at edge E0; RUN steps at E1..E2N.
  - done=1 in the cycle after E2N, for exactly one cycle (N=2: done is high 4 cycles after the dov edge).
  - busy is high in the cycles after E0 through E2N, and low in the done cycle.
- Throughput: a dov in the done cycle (FSM back in IDLE) is accepted, giving one operation per 2N+1 cycles.
- dov while busy=1 is ignored; it is not queued and does not perturb the operation in progress.
- Operands are captured at accept; input changes during RUN have no effect.
- Divide by zero (captured divisor=0): every trial succeeds. Result is quotient = all ones, remainder = dividend[N-1:0], div_by_zero=1. Latency is the same as a normal operation unless the optional feature is compiled in.
- Arithmetic:
  - Unsigned only. For divisor≠0: dividend = quotient*divisor + remainder, with remainder < divisor.
  - Partial remainder is N+1 bits so the trial subtract cannot overflow.
- Outputs quotient, remainder and div_by_zero change only on the completion edge or on reset.

Optional Feature:
RESTDIV_DIVZ_FAST_EN
- Defined: a dov accepted with divisor=0 skips RUN.
  - At the next edge (E1), outputs load quotient=all ones, remainder=dividend[N-1:0], div_by_zero=1.
  - done pulses in the cycle after E1 (latency 1); busy=1 only in the cycle after E0.
- Undefined: divisor=0 takes the full 2N-step path with identical result values.
- Non-zero divisors behave identically in both builds.

Test Plan:
- N=2, reset 3 cycles, then dividend=9, divisor=2, dov 1 cycle -> done exactly 4 cycles after dov edge; quotient=4, remainder=1, div_by_zero=0; busy high for the 4 cycles before done, 0 during done.
- dividend=15, divisor=3, then dov with dividend=6, divisor=1 in the done cycle -> first result q=5, r=0; second accepted back-to-back, done 5 cycles after first done, q=6, r=0.
- dividend=6, divisor=0 -> q=15, r=2, div_by_zero=1. done after 4 cycles without RESTDIV_DIVZ_FAST_EN, after 1 cycle with it.
- Start 13/3, assert dov with 8/2 two cycles later (busy) -> second ignored; only one done, q=4, r=1; no further done.
- Start 12/3, assert reset on the second RUN cycle -> next cycle all outputs 0, busy=0; no done pulse; a new 10/3 afterwards gives q=3, r=1 after 4 cycles.
- Exhaustive N=2: all 16 dividends x 4 divisors -> every result matches the reference model (q=dividend/divisor, r=dividend%divisor for divisor≠0; zero-divisor rule otherwise). Also chain with the 2x2 multiplier: (a*b)/b returns q=a, r=0 for all b≠0.
